// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter between the
// MIPS32 MEM stage and the debug/loader port.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int WCNT_W     = 4;

    typedef enum logic [1:0] {
        RUN,
        LOCKED,
        RELEASE
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE,
        PIPE,
        DBG
    } rd_owner_e;

endpackage

// File: rtl/dmem_wait_ctr.sv
// Saturating count of cycles a debug request has been held off by the
// pipeline; a clear (grant or dropped request) takes precedence over counting.
module dmem_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_x,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [WCNT_W-1:0] cnt_o
);

    logic [WCNT_W-1:0] cnt_q;
    logic [WCNT_W-1:0] cnt_d;
    logic              sat;

    assign sat   = (cnt_q == WCNT_W'(MAX_WAIT));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline has priority, debug gets a forced
// grant after MAX_WAIT blocked cycles, and lock mode hands the loader the memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_x,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    input  logic              d_lock,
    output logic              locked,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e        state_q, state_d;
    rd_owner_e         rd_owner_q, rd_owner_d;
    logic [WCNT_W-1:0] wcnt;
    logic              wait_sat;
    logic              dbg_gnt, pipe_gnt, stall_raw;
    logic              dbg_go, pipe_go;

    assign wait_sat = (wcnt == WCNT_W'(MAX_WAIT));

    always_comb begin
        dbg_gnt   = 1'b0;
        pipe_gnt  = 1'b0;
        stall_raw = 1'b0;
        state_d   = state_q;
        unique case (state_q)
            RUN: begin
                dbg_gnt   = d_valid & (~p_req | wait_sat);
                pipe_gnt  = p_req & ~dbg_gnt;
                stall_raw = p_req & dbg_gnt;
                if (d_lock) state_d = LOCKED;
            end
            LOCKED: begin
                dbg_gnt   = d_valid;
                stall_raw = 1'b1;
                if (!d_lock) state_d = RELEASE;
            end
            RELEASE: begin
                stall_raw = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Grants are masked while reset is held so the memory never sees an access.
    assign dbg_go  = dbg_gnt & rst_n;
    assign pipe_go = pipe_gnt & rst_n;
    assign d_ready = dbg_go;
    assign p_stall = stall_raw & rst_n;
    assign m_en    = dbg_go | pipe_go;
    assign locked  = (state_q != RUN);

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (dbg_go) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (pipe_go) begin
            m_we    = p_we;
            m_addr  = p_addr;
            m_wdata = p_wdata;
        end
    end

    always_comb begin
        rd_owner_d = NONE;
        if (dbg_go && !d_we) begin
            rd_owner_d = DBG;
        end else if (pipe_go && !p_we) begin
            rd_owner_d = PIPE;
        end
    end

    assign d_rvalid = (rd_owner_q == DBG);
    assign d_rdata  = m_rdata;
    assign p_rdata  = m_rdata;

    dmem_wait_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_ctr (
        .clk_x(clk_x),
        .rst_n(rst_n),
        .inc_i(d_valid & ~dbg_go),
        .clr_i(dbg_go | ~d_valid),
        .cnt_o(wcnt)
    );

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            rd_owner_q <= NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 1024x32 data memory between the MIPS32 pipeline MEM stage and a debug/loader port.
- The pipeline has default priority.
- A debug requester is guaranteed service after MAX_WAIT blocked cycles.
- A lock mode gives the loader exclusive memory ownership with the pipeline stalled, so memory preload and inspection go through real hardware.

Parameters:
ADDR_W, 10, word address width (1024 words)
DATA_W, 32, data width
MAX_WAIT, 4, blocked-cycle count after which a pending debug request beats the pipeline (1..15)

Ports:
clk_x  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
p_req  in  1  pipeline MEM-stage access valid this cycle
p_we  in  1  pipeline write (1) / read (0)
p_addr  in  ADDR_W  pipeline word address
p_wdata  in  DATA_W  pipeline write data
p_rdata  out  DATA_W  pipeline read data, valid the cycle after the accepted read
p_stall  out  1  pipeline must hold MEM stage and re-present its request
d_valid  in  1  debug request valid
d_ready  out  1  debug request accepted this cycle
d_we  in  1  debug write/read
d_addr  in  ADDR_W  debug address
d_wdata  in  DATA_W  debug write data
d_rdata  out  DATA_W  debug read data
d_rvalid  out  1  d_rdata valid (one-cycle pulse)
d_lock  in  1  level: loader requests exclusive ownership
locked  out  1  exclusive ownership active
m_en  out  1  memory enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, synchronous, one cycle after m_en with !m_we

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=RUN, wcnt=0, rd_owner=NONE, locked=0, d_rvalid=0.
  - While rst_n is low, m_en, d_ready and p_stall are forced to 0.
  - An outstanding read response is discarded.
- FSM states RUN, LOCKED, RELEASE:
  - RUN->LOCKED when d_lock=1 at the edge.
  - LOCKED->RELEASE when d_lock=0.
  - RELEASE->RUN unconditionally after one cycle (drains the last debug read response).
  - locked=1 in LOCKED and RELEASE.
- Grant in RUN (combinational):
  - dbg_gnt = d_valid & (!p_req | wcnt==MAX_WAIT).
  - pipe_gnt = p_req & !dbg_gnt.
- Grant in LOCKED:
  - dbg_gnt = d_valid, pipe_gnt=0, p_stall=1 every cycle.
- Grant in RELEASE:
  - no grants, p_stall=1.
- Stall and handshake:
  - p_stall in RUN = p_req & dbg_gnt.
  - d_ready = dbg_gnt; a transfer occurs on d_valid & d_ready.
- Memory mux:
  - m_en = dbg_gnt|pipe_gnt.
  - m_we/m_addr/m_wdata come from the granted requester; they are 0 when idle.
- Wait counter wcnt:
  - Increments, saturating at MAX_WAIT, when d_valid & !d_ready.
  - Clears on a debug grant or when d_valid=0.
- Back-to-back forced grants:
  - A forced grant (wcnt==MAX_WAIT) clears wcnt, so the pipeline wins the next cycle if it requests.
  - A debug requester may win consecutive cycles only when p_req=0.
- Read response:
  - rd_owner is registered from the granted read.
  - On the next cycle: if rd_owner=DBG, d_rvalid=1 and d_rdata=m_rdata. p_rdata=m_rdata always; the pipeline samples it only after its own read.
- Writes produce no response.
- Simultaneous d_lock rise and pending pipeline request: that cycle is still arbitrated as RUN. Stalling starts the following cycle.
- d_lock toggling inside RELEASE is ignored until RUN.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum {RUN, LOCKED, RELEASE}
  - the rd_owner enum {NONE, PIPE, DBG}
  - the default ADDR_W/DATA_W constants
- One natural sub-module, dmem_wait_ctr: the saturating wait counter with a grant-clear input.

Test Plan:
- Reset: assert rst_n=0 with p_req=1 and d_valid=1 -> m_en=0, d_ready=0, p_stall=0, d_rvalid=0, locked=0.
- Pipeline only: read p_addr=3 with mem[3]=0xDEADBEEF -> m_en=1, m_addr=3; next cycle p_rdata=0xDEADBEEF, p_stall=0.
- Contention, MAX_WAIT=4: p_req held high for 10 cycles, debug read d_addr=1 -> d_ready=0 for 4 cycles, granted on cycle 5 with p_stall=1 that cycle. d_rvalid follows one cycle later with mem[1]. Pipeline is granted the cycle after.
- Idle pipeline: debug write d_addr=2, d_wdata=0x12345678 -> d_ready same cycle, m_we=1. A later debug read of address 2 returns 0x12345678 with no d_rvalid on the write.
- Lock: d_lock=1, then 4 debug writes to addresses 0..3 while p_req=1 -> locked=1 and p_stall=1 throughout, and all 4 accepted back-to-back. d_lock=0 -> one RELEASE cycle with p_stall=1, then RUN with the pipeline granted.
- Reset mid-read: debug read granted, rst_n low before the response -> d_rvalid never asserts. After release, state=RUN and wcnt=0.
